alu_result_fifo: RTL

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_result_fifo.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_fifo
// Purpose  : Buffers ALU results ({op, y, flags}) in a DEPTH-entry FIFO with
//            valid/ready handshakes on both sides. Also accumulates sticky
//            carry / overflow / illegal-opcode status and a saturating count
//            of accepted overflow results.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH       number of buffered entries (power of two, 2..16)
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    upstream result valid
//   in_ready    entry can be accepted this cycle (independent of out_ready)
//   in_op       3-bit opcode (110/111 illegal)
//   in_y        32-bit result
//   in_flags    {z,n,c,v}
//   out_valid   head entry present
//   out_ready   downstream consumes head this cycle
//   out_op      head opcode
//   out_y       head result
//   out_flags   head flags
//   count       current occupancy, 0..DEPTH
//   clr_sticky  clear sticky status bits and ovf_cnt
//   sticky_c    sticky carry seen on an accepted entry
//   sticky_v    sticky overflow seen on an accepted entry
//   sticky_ill  sticky illegal opcode seen on an accepted entry
//   ovf_cnt     accepted entries with v=1, saturating at 16'hFFFF
// ============================================================================
module alu_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [31:0]                in_y,
  input  logic [3:0]                 in_flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_op,
  output logic [31:0]                out_y,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       clr_sticky,
  output logic                       sticky_c,
  output logic                       sticky_v,
  output logic                       sticky_ill,
  output logic [15:0]                ovf_cnt
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam int              EW      = 3 + 4 + 32;
  localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);
  localparam logic [15:0]     C_OVF_MAX = 16'hFFFF;

  // Entry storage; contents are don't-care while empty, so no reset.
  logic [EW-1:0]  r_mem [DEPTH];

  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  // Held low through reset so in_ready stays low until the first edge
  // after rst_n releases, even though the FIFO is empty.
  logic           r_ready_en;
  logic           r_sticky_c;
  logic           r_sticky_v;
  logic           r_sticky_ill;
  logic [15:0]    r_ovf_cnt;

  logic           w_in_ready;
  logic           w_out_valid;
  logic           w_push;
  logic           w_pop;
  logic [EW-1:0]  w_head;

  // Sticky/counter next-state: clear first, then fold in the push update.
  logic           w_sc_base;
  logic           w_sv_base;
  logic           w_si_base;
  logic [15:0]    w_ovf_base;
  logic           w_sc_next;
  logic           w_sv_next;
  logic           w_si_next;
  logic [15:0]    w_ovf_next;

  assign w_in_ready  = r_ready_en && (r_count < C_DEPTH);
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid && w_in_ready;
  assign w_pop       = w_out_valid && out_ready;

  assign w_head      = r_mem[r_rd_ptr];

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign out_op      = w_head[EW-1 -: 3];
  assign out_flags   = w_head[35:32];
  assign out_y       = w_head[31:0];
  assign count       = r_count;
  assign sticky_c    = r_sticky_c;
  assign sticky_v    = r_sticky_v;
  assign sticky_ill  = r_sticky_ill;
  assign ovf_cnt     = r_ovf_cnt;

  always_comb begin
    w_sc_base  = clr_sticky ? 1'b0  : r_sticky_c;
    w_sv_base  = clr_sticky ? 1'b0  : r_sticky_v;
    w_si_base  = clr_sticky ? 1'b0  : r_sticky_ill;
    w_ovf_base = clr_sticky ? 16'h0 : r_ovf_cnt;

    w_sc_next  = w_sc_base;
    w_sv_next  = w_sv_base;
    w_si_next  = w_si_base;
    w_ovf_next = w_ovf_base;

    if (w_push) begin
      w_sc_next = w_sc_base | in_flags[1];
      w_sv_next = w_sv_base | in_flags[0];
      w_si_next = w_si_base | (in_op[2:1] == 2'b11);
      if (in_flags[0] && (w_ovf_base != C_OVF_MAX)) begin
        w_ovf_next = w_ovf_base + 16'd1;
      end
    end
  end

  // Storage write: entries are kept verbatim.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_op, in_flags, in_y};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_ready_en   <= 1'b0;
      r_sticky_c   <= 1'b0;
      r_sticky_v   <= 1'b0;
      r_sticky_ill <= 1'b0;
      r_ovf_cnt    <= 16'h0;
    end else begin
      r_ready_en   <= 1'b1;
      r_sticky_c   <= w_sc_next;
      r_sticky_v   <= w_sv_next;
      r_sticky_ill <= w_si_next;
      r_ovf_cnt    <= w_ovf_next;

      // Power-of-two depth: pointers wrap from DEPTH-1 to 0 naturally.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
